sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Avalon-MM master that copies a rectangular sprite from an SRAM source region into the 640x480 16-bit framebuffer.
- Issues its reads and writes into the SRAM time-multiplexer's Avalon-MM slave port, i.e. it is the initiator side of that slave.
- Supports a transparent colour key and screen-edge clipping.
- Runs on CLK2, the 2x SRAM clock. Requests are held long enough to span one Avalon slot of the multiplexer.

Parameters:
SCREEN_W, 640, framebuffer width in pixels (destination row stride)
SCREEN_H, 480, framebuffer height in pixels
SLOT_CYCLES, 2, CLK2 cycles each AVL_READ/AVL_WRITE request is held
READ_LATENCY, 2, CLK2 cycles after the read request ends until AVL_READDATA is sampled

Ports:
CLK2  in  1  clock, 2x SRAM clock
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle command strobe; sampled only in IDLE
SRC_BASE  in  20  SRAM word address of sprite pixel (0,0); sprite is row-major, stride WIDTH
DST_X  in  10  destination column of sprite origin
DST_Y  in  10  destination row of sprite origin
WIDTH  in  10  sprite width in pixels
HEIGHT  in  10  sprite height in pixels
KEY_EN  in  1  enable transparent colour key
KEY_COLOR  in  16  transparent colour value
BUSY  out  1  high while a blit is in progress
DONE  out  1  one-cycle pulse at end of blit
AVL_READ  out  1  Avalon-MM read request
AVL_WRITE  out  1  Avalon-MM write request
AVL_ADDR  out  20  Avalon-MM word address
AVL_WRITEDATA  out  16  Avalon-MM write data
AVL_READDATA  in  16  Avalon-MM read data

Behaviour:
- Reset: RESET is synchronous, active-high, clock CLK2.
  - All outputs are 0 after reset: BUSY, DONE, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA.
  - State returns to IDLE.
  - Asserting RESET mid-blit aborts on the next edge. No DONE pulse is produced.
- States: IDLE, SETUP, PIX, RD, WAIT, WR, FIN.
- IDLE:
  - START=1 latches all command inputs and moves to SETUP.
  - START in any other state is ignored.
- SETUP (1 cycle):
  - Sets col=0, row=0 and src=SRC_BASE.
  - Sets dst_row_base = DST_Y*SCREEN_W + DST_X, computed modulo 2^20.
  - BUSY=1 from this cycle through FIN inclusive.
  - If WIDTH==0 or HEIGHT==0, goes to FIN with no bus activity; otherwise goes to PIX.
- PIX (1 cycle):
  - Clip test: (DST_X+col) >= SCREEN_W or (DST_Y+row) >= SCREEN_H, using 11-bit sums.
  - Clipped: advance the pixel (see below), with no bus activity.
  - Not clipped: go to RD.
- RD (SLOT_CYCLES cycles): AVL_READ=1, AVL_ADDR=src.
- WAIT (READ_LATENCY cycles):
  - AVL_READ=0.
  - AVL_READDATA is captured into pix_reg on the last WAIT cycle.
  - If KEY_EN=1 and pix_reg==KEY_COLOR, advance with no write; else go to WR.
- WR (SLOT_CYCLES cycles): AVL_WRITE=1, AVL_ADDR=dst_row_base+col, AVL_WRITEDATA=pix_reg.
- Advance:
  - src += 1, col += 1.
  - If col reaches WIDTH: col=0, row += 1, dst_row_base += SCREEN_W.
  - If row reaches HEIGHT: go to FIN; else go to PIX.
- AVL_READ and AVL_WRITE are never high together. Both are 0 outside RD/WR.
- FIN (1 cycle): DONE=1, then IDLE with BUSY=0.
- Timing:
  - START-to-first-request latency is 2 cycles (SETUP, PIX).
  - Per-pixel cost with defaults: drawn 7 cycles, keyed 5, clipped 1.
  - Total blit = 1 (SETUP) + sum of per-pixel costs + 1 (FIN).
- Address arithmetic is modulo 2^20 and wraps silently.

Optional Feature:
- Macro: SPRITE_BLITTER_FILL_EN.
- When defined, adds ports FILL_MODE (in, 1) and FILL_COLOR (in, 16), both latched at START.
- With FILL_MODE=1:
  - PIX goes directly to WR for unclipped pixels, skipping RD and WAIT.
  - pix_reg = FILL_COLOR. The colour key is not applied. src still increments.
  - Drawn-pixel cost is 3 cycles.
- When the macro is undefined, these ports do not exist and behaviour is as above.

Test Plan:
- Basic blit: SRC_BASE=0x80000, DST=(0,0), 2x1, memory model returns 0x1234 then 0xABCD.
  -> Reads at 0x80000 and 0x80001; writes 0x1234@0x00000 and 0xABCD@0x00001; DONE pulses 16 cycles after START; each request is 2 cycles wide.
- Row stride: DST=(10,5), 2x2.
  -> Write addresses 0x00C8A, 0x00C8B, 0x00F0A, 0x00F0B; source reads SRC_BASE+0..3.
- Colour key: KEY_EN=1, KEY_COLOR=0xF81F, 3x1 sprite data {0x0001, 0xF81F, 0x0002}.
  -> Writes only at cols 0 and 2; 3 reads and 2 writes; blit takes 21 cycles.
- Clipping: DST=(639,479), 2x2.
  -> Exactly one read (SRC_BASE) and one write at 479*640+639=0x4AFFF; other pixels produce no bus activity; DONE still pulses.
- Degenerate and abort cases:
  - WIDTH=0 -> DONE at START+2 with no requests.
  - START while BUSY -> ignored.
  - RESET during WR -> AVL_WRITE=0 next edge, no DONE pulse, BUSY=0.
- Fill mode (SPRITE_BLITTER_FILL_EN defined): FILL_MODE=1, FILL_COLOR=0x07E0, DST=(0,0), 4x1.
  -> Four writes of 0x07E0 at addresses 0..3; no reads; DONE at START+14.

Source files
------------

// File: rtl/sprite_blitter.sv
// Avalon-MM master copying a row-major SRAM sprite into the 640x480x16 framebuffer,
// with colour key and screen-edge clipping. Define SPRITE_BLITTER_FILL_EN for solid-fill mode.
module sprite_blitter #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int SLOT_CYCLES  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic        CLK2,
    input  logic        RESET,
    input  logic        START,
    input  logic [19:0] SRC_BASE,
    input  logic [9:0]  DST_X,
    input  logic [9:0]  DST_Y,
    input  logic [9:0]  WIDTH,
    input  logic [9:0]  HEIGHT,
    input  logic        KEY_EN,
    input  logic [15:0] KEY_COLOR,
`ifdef SPRITE_BLITTER_FILL_EN
    input  logic        FILL_MODE,
    input  logic [15:0] FILL_COLOR,
`endif
    output logic        BUSY,
    output logic        DONE,
    output logic        AVL_READ,
    output logic        AVL_WRITE,
    output logic [19:0] AVL_ADDR,
    output logic [15:0] AVL_WRITEDATA,
    input  logic [15:0] AVL_READDATA
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PIX, S_RD, S_WAIT, S_WR, S_FIN
    } state_t;

    localparam logic [7:0]  SLOT_LAST = 8'(SLOT_CYCLES - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(READ_LATENCY - 1);
    localparam logic [10:0] SCR_W_11  = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H_11  = 11'(SCREEN_H);
    localparam logic [19:0] SCR_W_20  = 20'(SCREEN_W);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] src_q, src_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [19:0] dst_base_q, dst_base_d;
    logic [15:0] pix_q, pix_d;

    // Command latched at START
    logic [19:0] src_base_q, src_base_d;
    logic [9:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [9:0]  width_q, width_d, height_q, height_d;
    logic        key_en_q, key_en_d;
    logic [15:0] key_color_q, key_color_d;
`ifdef SPRITE_BLITTER_FILL_EN
    logic        fill_mode_q, fill_mode_d;
    logic [15:0] fill_color_q, fill_color_d;
`endif

    logic [9:0] col_inc, row_inc;
    logic       row_wrap, last_pix, clipped, advance;

    assign col_inc  = col_q + 10'd1;
    assign row_inc  = row_q + 10'd1;
    assign row_wrap = (col_inc == width_q);
    assign last_pix = row_wrap && (row_inc == height_q);
    assign clipped  = (({1'b0, dst_x_q} + {1'b0, col_q}) >= SCR_W_11) ||
                      (({1'b0, dst_y_q} + {1'b0, row_q}) >= SCR_H_11);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        col_d       = col_q;
        row_d       = row_q;
        dst_base_d  = dst_base_q;
        pix_d       = pix_q;
        src_base_d  = src_base_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        width_d     = width_q;
        height_d    = height_q;
        key_en_d    = key_en_q;
        key_color_d = key_color_q;
`ifdef SPRITE_BLITTER_FILL_EN
        fill_mode_d  = fill_mode_q;
        fill_color_d = fill_color_q;
`endif
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    src_base_d  = SRC_BASE;
                    dst_x_d     = DST_X;
                    dst_y_d     = DST_Y;
                    width_d     = WIDTH;
                    height_d    = HEIGHT;
                    key_en_d    = KEY_EN;
                    key_color_d = KEY_COLOR;
`ifdef SPRITE_BLITTER_FILL_EN
                    fill_mode_d  = FILL_MODE;
                    fill_color_d = FILL_COLOR;
`endif
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                col_d      = '0;
                row_d      = '0;
                src_d      = src_base_q;
                dst_base_d = 20'(dst_y_q) * SCR_W_20 + 20'(dst_x_q);
                state_d    = (width_q == '0 || height_q == '0) ? S_FIN : S_PIX;
            end
            S_PIX: begin
                cnt_d = '0;
                if (clipped) begin
                    advance = 1'b1;
                end else begin
`ifdef SPRITE_BLITTER_FILL_EN
                    if (fill_mode_q) begin
                        pix_d   = fill_color_q;
                        state_d = S_WR;
                    end else
`endif
                    state_d = S_RD;
                end
            end
            S_RD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SLOT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WAIT_LAST) begin
                    // Key decision uses the word being captured, so a keyed pixel costs no extra cycle
                    pix_d = AVL_READDATA;
                    cnt_d = '0;
                    if (key_en_q && (AVL_READDATA == key_color_q))
                        advance = 1'b1;
                    else
                        state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SLOT_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            src_d = src_q + 20'd1;
            if (row_wrap) begin
                col_d      = '0;
                row_d      = row_inc;
                dst_base_d = dst_base_q + SCR_W_20;
            end else begin
                col_d = col_inc;
            end
            state_d = last_pix ? S_FIN : S_PIX;
        end
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: datapath registers carry no reset; every output is gated by state, so they read 0 in IDLE.
    always_ff @(posedge CLK2) begin
        src_q       <= src_d;
        col_q       <= col_d;
        row_q       <= row_d;
        dst_base_q  <= dst_base_d;
        pix_q       <= pix_d;
        src_base_q  <= src_base_d;
        dst_x_q     <= dst_x_d;
        dst_y_q     <= dst_y_d;
        width_q     <= width_d;
        height_q    <= height_d;
        key_en_q    <= key_en_d;
        key_color_q <= key_color_d;
`ifdef SPRITE_BLITTER_FILL_EN
        fill_mode_q  <= fill_mode_d;
        fill_color_q <= fill_color_d;
`endif
    end

    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_FIN);
    assign AVL_READ      = (state_q == S_RD);
    assign AVL_WRITE     = (state_q == S_WR);
    assign AVL_ADDR      = (state_q == S_RD) ? src_q :
                           (state_q == S_WR) ? dst_base_q + 20'(col_q) : '0;
    assign AVL_WRITEDATA = (state_q == S_WR) ? pix_q : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter: bus-trace monitor, SRAM read model,
// one task per scenario. Fill-mode scenario runs when SPRITE_BLITTER_FILL_EN is defined.
`timescale 1ns/1ps
module tb_sprite_blitter;

    localparam int SLOT = 2;

    logic        CLK2 = 1'b0;
    logic        RESET, START, KEY_EN;
    logic [19:0] SRC_BASE;
    logic [9:0]  DST_X, DST_Y, WIDTH, HEIGHT;
    logic [15:0] KEY_COLOR;
`ifdef SPRITE_BLITTER_FILL_EN
    logic        FILL_MODE;
    logic [15:0] FILL_COLOR;
`endif
    logic        BUSY, DONE, AVL_READ, AVL_WRITE;
    logic [19:0] AVL_ADDR;
    logic [15:0] AVL_WRITEDATA;
    logic [15:0] rdata = 16'h0000;

    sprite_blitter dut (
        .CLK2(CLK2), .RESET(RESET), .START(START), .SRC_BASE(SRC_BASE),
        .DST_X(DST_X), .DST_Y(DST_Y), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .KEY_EN(KEY_EN), .KEY_COLOR(KEY_COLOR),
`ifdef SPRITE_BLITTER_FILL_EN
        .FILL_MODE(FILL_MODE), .FILL_COLOR(FILL_COLOR),
`endif
        .BUSY(BUSY), .DONE(DONE), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(rdata)
    );

    always #5 CLK2 = ~CLK2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;

    always @(posedge CLK2) cyc <= cyc + 1;

    // SRAM source model: word presented after the read request and held until the next read
    logic [15:0] src_mem [16];
    logic [19:0] mem_base = '0;
    always @(posedge CLK2) if (AVL_READ) rdata <= src_mem[4'(AVL_ADDR - mem_base)];

    // Bus trace
    logic [19:0] rd_addr_q[$];
    logic [19:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int rd_run, wr_run, bad_len, overlap, done_cnt, done_cyc, first_req_cyc;
    logic prev_rd = 1'b0, prev_wr = 1'b0;

    always @(negedge CLK2) begin
        if (AVL_READ && !prev_rd) begin
            rd_addr_q.push_back(AVL_ADDR);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (AVL_WRITE && !prev_wr) begin
            wr_addr_q.push_back(AVL_ADDR);
            wr_data_q.push_back(AVL_WRITEDATA);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (AVL_READ) rd_run++;
        else begin
            if (prev_rd && rd_run != SLOT) bad_len++;
            rd_run = 0;
        end
        if (AVL_WRITE) wr_run++;
        else begin
            if (prev_wr && wr_run != SLOT) bad_len++;
            wr_run = 0;
        end
        if (AVL_READ && AVL_WRITE) overlap++;
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_rd = AVL_READ;
        prev_wr = AVL_WRITE;
    end

    task automatic tick();
        @(negedge CLK2);
        #1;
    endtask

    task automatic clear_trace();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        bad_len = 0; overlap = 0; done_cnt = 0; done_cyc = -1; first_req_cyc = -1;
    endtask

    task automatic start_blit(input logic [19:0] sb, input logic [9:0] dx, input logic [9:0] dy,
                              input logic [9:0] w, input logic [9:0] h,
                              input logic ke, input logic [15:0] kc);
        clear_trace();
        SRC_BASE = sb; DST_X = dx; DST_Y = dy; WIDTH = w; HEIGHT = h;
        KEY_EN = ke; KEY_COLOR = kc; mem_base = sb;
        start_cyc = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 500) begin
            tick();
            t++;
        end
        if (done_cnt == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: DONE not seen within 500 cycles", name);
        end
        tick();
    endtask

    task automatic check_common(input string name, input int exp_lat, input int exp_rd, input int exp_wr);
        n_checks++;
        if (done_cyc - start_cyc !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, done_cyc - start_cyc, exp_lat);
        end
        n_checks++;
        if (rd_addr_q.size() !== exp_rd || wr_addr_q.size() !== exp_wr) begin
            n_fail++;
            $display("FAIL %s counts: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     name, rd_addr_q.size(), wr_addr_q.size(), exp_rd, exp_wr);
        end
        n_checks++;
        if (bad_len !== 0 || overlap !== 0 || done_cnt !== 1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s protocol: got bad_len=%0d overlap=%0d done_cnt=%0d busy=%b expected 0 0 1 0",
                     name, bad_len, overlap, done_cnt, BUSY);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        n_checks++;
        if ({BUSY, DONE, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {BUSY, DONE, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA});
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        src_mem[0] = 16'h1234; src_mem[1] = 16'hABCD;
        start_blit(20'h80000, 10'd0, 10'd0, 10'd2, 10'd1, 1'b0, 16'h0000);
        wait_done("basic");
        check_common("basic", 16, 2, 2);
        n_checks++;
        if (first_req_cyc - start_cyc !== 3) begin
            n_fail++; $display("FAIL basic first_req: got %0d expected 3", first_req_cyc - start_cyc);
        end
        n_checks++;
        if ({rd_addr_q[0], rd_addr_q[1]} !== {20'h80000, 20'h80001}) begin
            n_fail++; $display("FAIL basic rd_addr: got %h %h expected 80000 80001", rd_addr_q[0], rd_addr_q[1]);
        end
        n_checks++;
        if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !==
            {20'h00000, 16'h1234, 20'h00001, 16'hABCD}) begin
            n_fail++;
            $display("FAIL basic writes: got %h=%h %h=%h expected 00000=1234 00001=abcd",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        end
    endtask

    task automatic test_stride();
        logic [19:0] exp_wr [4];
        exp_wr[0] = 20'h00C8A; exp_wr[1] = 20'h00C8B; exp_wr[2] = 20'h00F0A; exp_wr[3] = 20'h00F0B;
        for (int i = 0; i < 4; i++) src_mem[i] = 16'h0100 + 16'(i);
        start_blit(20'h00100, 10'd10, 10'd5, 10'd2, 10'd2, 1'b0, 16'h0000);
        wait_done("stride");
        check_common("stride", 30, 4, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_addr_q[i] !== 20'h00100 + 20'(i) || wr_addr_q[i] !== exp_wr[i] ||
                wr_data_q[i] !== 16'h0100 + 16'(i)) begin
                n_fail++;
                $display("FAIL stride px%0d: got rd=%h wr=%h data=%h expected rd=%h wr=%h data=%h",
                         i, rd_addr_q[i], wr_addr_q[i], wr_data_q[i],
                         20'h00100 + 20'(i), exp_wr[i], 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_key();
        src_mem[0] = 16'h0001; src_mem[1] = 16'hF81F; src_mem[2] = 16'h0002;
        start_blit(20'h00200, 10'd0, 10'd0, 10'd3, 10'd1, 1'b1, 16'hF81F);
        wait_done("key");
        check_common("key", 21, 3, 2);
        n_checks++;
        if ({wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !==
            {20'h00000, 16'h0001, 20'h00002, 16'h0002}) begin
            n_fail++;
            $display("FAIL key writes: got %h=%h %h=%h expected 00000=0001 00002=0002",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        end
    endtask

    task automatic test_clip();
        src_mem[0] = 16'h5555;
        start_blit(20'h00300, 10'd639, 10'd479, 10'd2, 10'd2, 1'b0, 16'h0000);
        wait_done("clip");
        check_common("clip", 12, 1, 1);
        n_checks++;
        if ({rd_addr_q[0], wr_addr_q[0], wr_data_q[0]} !== {20'h00300, 20'h4AFFF, 16'h5555}) begin
            n_fail++;
            $display("FAIL clip bus: got rd=%h wr=%h data=%h expected 00300 4afff 5555",
                     rd_addr_q[0], wr_addr_q[0], wr_data_q[0]);
        end
    endtask

    task automatic test_zero_size();
        start_blit(20'h00000, 10'd0, 10'd0, 10'd0, 10'd4, 1'b0, 16'h0000);
        wait_done("zero_w");
        check_common("zero_w", 2, 0, 0);
        start_blit(20'h00000, 10'd0, 10'd0, 10'd4, 10'd0, 1'b0, 16'h0000);
        wait_done("zero_h");
        check_common("zero_h", 2, 0, 0);
    endtask

    task automatic test_start_ignored();
        src_mem[0] = 16'h1111; src_mem[1] = 16'h2222;
        start_blit(20'h80000, 10'd0, 10'd0, 10'd2, 10'd1, 1'b0, 16'h0000);
        tick(); tick(); tick();
        WIDTH = 10'd5; DST_X = 10'd100; START = 1'b1;
        tick();
        START = 1'b0;
        wait_done("busy_start");
        check_common("busy_start", 16, 2, 2);
        repeat (20) tick();
        n_checks++;
        if (done_cnt !== 1 || BUSY !== 1'b0 || wr_addr_q[1] !== 20'h00001) begin
            n_fail++;
            $display("FAIL busy_start_after: got done_cnt=%0d busy=%b wr1=%h expected 1 0 00001",
                     done_cnt, BUSY, wr_addr_q[1]);
        end
    endtask

    task automatic test_reset_abort();
        int t = 0;
        src_mem[0] = 16'h3333;
        start_blit(20'h80000, 10'd3, 10'd0, 10'd1, 10'd1, 1'b0, 16'h0000);
        while (!AVL_WRITE && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (AVL_WRITE !== 1'b1) begin
            n_fail++; $display("FAIL abort_reach_wr: got write=%b expected 1", AVL_WRITE);
        end
        RESET = 1'b1;
        tick();
        n_checks++;
        if ({AVL_WRITE, BUSY, DONE, AVL_ADDR} !== 23'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got write=%b busy=%b done=%b addr=%h expected all 0",
                     AVL_WRITE, BUSY, DONE, AVL_ADDR);
        end
        RESET = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (done_cnt !== 0 || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: got done_cnt=%0d busy=%b expected 0 0", done_cnt, BUSY);
        end
    endtask

`ifdef SPRITE_BLITTER_FILL_EN
    task automatic test_fill();
        FILL_MODE = 1'b1; FILL_COLOR = 16'h07E0;
        start_blit(20'h00400, 10'd0, 10'd0, 10'd4, 10'd1, 1'b1, 16'h07E0);
        FILL_MODE = 1'b0;
        wait_done("fill");
        check_common("fill", 14, 0, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr_q[i] !== 20'(i) || wr_data_q[i] !== 16'h07E0) begin
                n_fail++;
                $display("FAIL fill px%0d: got %h=%h expected %h=07e0", i, wr_addr_q[i], wr_data_q[i], 20'(i));
            end
        end
    endtask
`endif

    initial begin
        RESET = 1'b1; START = 1'b0; KEY_EN = 1'b0; KEY_COLOR = '0;
        SRC_BASE = '0; DST_X = '0; DST_Y = '0; WIDTH = '0; HEIGHT = '0;
`ifdef SPRITE_BLITTER_FILL_EN
        FILL_MODE = 1'b0; FILL_COLOR = '0;
`endif
        for (int i = 0; i < 16; i++) src_mem[i] = '0;
        clear_trace();
        test_reset();
        test_basic();
        test_stride();
        test_key();
        test_clip();
        test_zero_size();
        test_start_ignored();
        test_reset_abort();
`ifdef SPRITE_BLITTER_FILL_EN
        test_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
